// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit.
//   SIZE_*        : req_size encodings (2'b11 is reserved and always faults)
//   lsu_state_t   : sequencer states
//   is_misaligned : alignment / reserved-size check on a request
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACCESS   = 2'b01,
    MERGE_WR = 2'b10
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = off[0];
      SIZE_WORD: is_misaligned = (off != 2'b00);
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational lane steering between a 32-bit DMEM word and sub-word data.
//   word        in  : word currently read from DMEM
//   off         in  : byte offset addr[1:0] (little-endian lanes)
//   size        in  : access size encoding
//   is_unsigned in  : loads only, 1 = zero-extend
//   wdata       in  : right-aligned store data
//   load_data   out : selected lane, sign/zero extended to 32 bits
//   merged      out : word with the addressed lane(s) replaced by wdata
module byte_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        off,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic signed [DATA_W-1:0] byte_sx;
  logic signed [DATA_W-1:0] half_sx;

  always_comb begin
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];

    // Extension bit is the lane MSB for signed loads, zero otherwise.
    byte_sx = $signed({{24{byte_sel[7] & ~is_unsigned}}, byte_sel});
    half_sx = $signed({{16{half_sel[15] & ~is_unsigned}}, half_sel});

    case (size)
      SIZE_BYTE: load_data = byte_sx;
      SIZE_HALF: load_data = half_sx;
      default:   load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (size)
      SIZE_BYTE: begin
        case (off)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage sequencer: turns byte/half/word loads and stores into DMEM
// word accesses. Sub-word stores read-modify-write because DMEM has no
// byte enables; misaligned or reserved-size requests fault without touching DMEM.
//   req_*  : request handshake (req_ready high only in IDLE)
//   rsp_*  : one-cycle completion pulse with load data and error flag
//   dmem_* : word-indexed DMEM port, combinational read, posedge write
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_data_in,
  output logic              dmem_mem_write,
  output logic              dmem_mem_read,
  input  logic [DATA_W-1:0] dmem_data_out
);

  lsu_state_t        state;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;
  logic              word_store;

  byte_lane_align #(.DATA_W(DATA_W)) u_align (
    .word        (dmem_data_out),
    .off         (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  assign req_ready    = (state == IDLE);
  assign word_store   = we_q && (size_q == SIZE_WORD);
  // addr_q is held from accept until the next accept, so the index is stable
  // across ACCESS -> MERGE_WR.
  assign dmem_address = {2'b00, addr_q[ADDR_W-1:2]};

  always_comb begin
    dmem_mem_read  = (state == ACCESS) && !word_store;
    dmem_mem_write = ((state == ACCESS) && word_store) || (state == MERGE_WR);
    dmem_data_in   = (state == MERGE_WR) ? merge_q : wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      merge_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            // Faulting requests complete straight from IDLE; rsp_rdata holds.
            if (is_misaligned(req_size, req_addr[1:0])) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rsp_rdata <= load_data;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end else if (word_store) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end else begin
            merge_q <= merged;
            state   <= MERGE_WR;
          end
        end
        MERGE_WR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic        dmem_mem_write;
  logic        dmem_mem_read;
  logic [31:0] dmem_data_out;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .dmem_address   (dmem_address),
    .dmem_data_in   (dmem_data_in),
    .dmem_mem_write (dmem_mem_write),
    .dmem_mem_read  (dmem_mem_read),
    .dmem_data_out  (dmem_data_out)
  );

  // DMEM: 64 words, combinational read, posedge write.
  logic [31:0] mem [0:63];
  always @(posedge clk) if (dmem_mem_write) mem[dmem_address[5:0]] <= dmem_data_in;
  assign dmem_data_out = mem[dmem_address[5:0]];

  // Reference memory and bookkeeping.
  logic [31:0] ref_mem [0:63];
  logic [31:0] last_rdata;
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_fault(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] v;
    v = word >> (8 * int'(off));
    if (size == 2'd0) begin
      v = v & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = v & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_store(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] off, input logic [1:0] size);
    logic [31:0] mask;
    int sh;
    sh   = 8 * int'(off);
    mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    mask = mask << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // One full request: drive, wait for the completion pulse (bounded), then
  // check latency, response, DMEM enable activity and the touched word.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    bit          fault;
    int          w, lat, rd, wr, busy, both, exp_lat;
    logic [31:0] exp_rd;
    w     = int'(addr[7:2]);
    fault = exp_fault(size, addr[1:0]);
    exp_lat = fault ? 1 : (we && size != 2'd2) ? 3 : 2;
    exp_rd  = (fault || we) ? last_rdata : exp_load(ref_mem[w], addr[1:0], size, uns);

    @(negedge clk);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = $urandom_range(0, 1);
    lat = 1; rd = 0; wr = 0; busy = 0; both = 0;
    while (!rsp_valid && lat < 8) begin
      if (dmem_mem_read) rd++;
      if (dmem_mem_write) wr++;
      if (dmem_mem_read && dmem_mem_write) both++;
      if (!req_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".err"}, 32'(rsp_err), {31'b0, fault});
    if (fault || !we) check({tag, ".rdata"}, rsp_rdata, exp_rd);
    check({tag, ".rd_cycles"}, 32'(rd), (fault || (we && size == 2'd2)) ? 32'd0 : 32'd1);
    check({tag, ".wr_cycles"}, 32'(wr), (!fault && we) ? 32'd1 : 32'd0);
    check({tag, ".rd_wr_both"}, 32'(both), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'(exp_lat - 1));
    if (!fault && we) ref_mem[w] = exp_store(ref_mem[w], wd, addr[1:0], size);
    check({tag, ".mem"}, mem[w], ref_mem[w]);
    if (fault || !we) last_rdata = exp_rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[1] = 32'h8899AABB; ref_mem[1] = 32'h8899AABB;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    last_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.rdata", rsp_rdata, 32'd0);
    check("rst.err",   32'(rsp_err), 32'd0);
    check("rst.en",    {30'b0, dmem_mem_read, dmem_mem_write}, 32'd0);

    // Directed loads on a preloaded word.
    do_req("lb5",  1'b0, 2'd0, 1'b0, 32'h5, 32'h0);
    check("lb5.value", rsp_rdata, 32'hFFFFFFAA);
    do_req("lbu7", 1'b0, 2'd0, 1'b1, 32'h7, 32'h0);
    check("lbu7.value", rsp_rdata, 32'h00000088);
    do_req("lh6",  1'b0, 2'd1, 1'b0, 32'h6, 32'h0);
    check("lh6.value", rsp_rdata, 32'hFFFF8899);
    do_req("lw4",  1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    check("lw4.value", rsp_rdata, 32'h8899AABB);

    // Stores.
    do_req("sb4",  1'b1, 2'd0, 1'b0, 32'h4, 32'h123456CC);
    check("sb4.word", mem[1], 32'h8899AACC);
    do_req("sh6",  1'b1, 2'd1, 1'b0, 32'h6, 32'h00007777);
    do_req("lw4b", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    check("lw4b.value", rsp_rdata, 32'h7777AACC);
    do_req("sw8",  1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF);
    check("sw8.word", mem[2], 32'hDEADBEEF);

    // Faults: no DMEM activity, rdata held.
    do_req("lw2",  1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
    do_req("sh3",  1'b1, 2'd1, 1'b0, 32'h3, 32'hFFFF);
    do_req("rsv",  1'b1, 2'd3, 1'b0, 32'h0, 32'h55);
    check("fault.mem1", mem[1], 32'h7777AACC);

    // Asynchronous reset in the write cycle of a sub-word store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h4; req_wdata = 32'h00000011;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("arst.access_rd", 32'(dmem_mem_read), 32'd1);
    @(posedge clk); #1;
    check("arst.merge_wr", 32'(dmem_mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst.wr_drop", 32'(dmem_mem_write), 32'd0);
    check("arst.ready",   32'(req_ready), 32'd1);
    check("arst.valid",   32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("arst.valid2",  32'(rsp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    check("arst.mem1", mem[1], ref_mem[1]);
    @(posedge clk); #1;
    check("arst.valid3", 32'(rsp_valid), 32'd0);
    check("arst.ready2", 32'(req_ready), 32'd1);
    check("arst.rdata",  rsp_rdata, 32'd0);
    last_rdata = 32'h0;

    // Randomised traffic against the reference model.
    for (int k = 0; k < 60; k++) begin
      logic        r_we;
      logic [1:0]  r_size;
      logic        r_uns;
      logic [31:0] r_addr;
      logic [31:0] r_wd;
      r_we   = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_uns  = 1'($urandom_range(0, 1));
      r_addr = 32'($urandom_range(0, 63));
      r_wd   = $urandom;
      do_req($sformatf("rnd%0d", k), r_we, r_size, r_uns, r_addr, r_wd);
    end

    for (int i = 0; i < 16; i++) check($sformatf("final.mem%0d", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
